game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_if.sv | 29 ++
 rtl/game_sequencer.sv | 158 +++++++++++++++
 tb/tb_game_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
`default_nettype none
// ============================================================================
// game_sequencer_if : button/renderer inputs and game status outputs
// Rev 1.0
// ============================================================================
interface game_sequencer_if;
  logic               start;
  logic               jump_btn;
  logic               hit;
  logic               pass;
  logic signed [10:0] y_coord;
  logic [1:0]         state;
  logic               enable;
  logic               jump;
  logic [1:0]         fall_accel;
  logic [7:0]         score;
  logic [7:0]         high_score;

  modport master (
    output start, jump_btn, hit, pass, y_coord,
    input  state, enable, jump, fall_accel, score, high_score
  );

  modport slave (
    input  start, jump_btn, hit, pass, y_coord,
    output state, enable, jump, fall_accel, score, high_score
  );
endinterface
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// game_sequencer : IDLE/READY/PLAY/OVER game flow, BCD scoring, jump stretch
// Rev 1.0
// ============================================================================
module game_sequencer #(
  parameter int TICK_DIV    = 32,
  parameter int READY_TICKS = 64,
  parameter int OVER_TICKS  = 128
) (
  input  wire logic          clk,
  input  wire logic          rst,
  game_sequencer_if.slave    bus
);

  localparam int c_TW    = $clog2(TICK_DIV);
  localparam int c_CMAX  = (READY_TICKS > OVER_TICKS) ? READY_TICKS : OVER_TICKS;
  localparam int c_CW    = $clog2(c_CMAX + 1);
  localparam logic [c_TW-1:0] c_TICK_MAX = c_TW'(TICK_DIV - 1);
  localparam logic [c_CW-1:0] c_READY_LD = c_CW'(READY_TICKS);
  localparam logic [c_CW-1:0] c_OVER_LD  = c_CW'(OVER_TICKS);

  typedef enum logic [1:0] {
    c_IDLE  = 2'd0,
    c_READY = 2'd1,
    c_PLAY  = 2'd2,
    c_OVER  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_enable;
  logic            r_jump;
  logic [1:0]      r_fall;
  logic [7:0]      r_score;
  logic [7:0]      r_high;
  logic [c_TW-1:0] r_tick_cnt;
  logic [c_CW-1:0] r_cd;

  // Synchronizer bit order {start, jump_btn, hit, pass}; third stage only for edge inputs
  logic [3:0]      r_sy0;
  logic [3:0]      r_sy1;
  logic [2:0]      r_sy2;

  logic            w_tick;
  logic            w_start_e;
  logic            w_jump_e;
  logic            w_pass_e;
  logic            w_hit;
  logic            w_exit;
  logic [7:0]      w_score_inc;

  function automatic logic [1:0] f_accel(input logic [3:0] tens);
    return (tens >= 4'd3) ? 2'd3 : tens[1:0];
  endfunction

  assign w_tick    = (r_tick_cnt == c_TICK_MAX);
  assign w_start_e = r_sy1[3] & ~r_sy2[2];
  assign w_jump_e  = r_sy1[2] & ~r_sy2[1];
  assign w_pass_e  = r_sy1[0] & ~r_sy2[0];
  assign w_hit     = r_sy1[1];
  assign w_exit    = w_hit | (w_tick & ($signed(bus.y_coord) <= 11'sd0));

  always_comb begin
    w_score_inc = r_score;
    if (r_score != 8'h99) begin
      if (r_score[3:0] == 4'd9) w_score_inc = {r_score[7:4] + 4'd1, 4'd0};
      else                      w_score_inc = {r_score[7:4], r_score[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sy0      <= '0;
      r_sy1      <= '0;
      r_sy2      <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_sy0      <= {bus.start, bus.jump_btn, bus.hit, bus.pass};
      r_sy1      <= r_sy0;
      r_sy2      <= {r_sy1[3], r_sy1[2], r_sy1[0]};
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= c_IDLE;
      r_enable <= 1'b0;
      r_jump   <= 1'b0;
      r_fall   <= 2'd0;
      r_score  <= 8'h00;
      r_high   <= 8'h00;
      r_cd     <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_start_e) begin
            r_state <= c_READY;
            r_score <= 8'h00;
            r_fall  <= 2'd0;
            r_cd    <= c_READY_LD;
          end
        end
        c_READY: begin
          if (w_jump_e) begin
            r_state  <= c_PLAY;
            r_enable <= 1'b1;
            r_cd     <= '0;
          end else if (w_tick) begin
            if (r_cd <= c_CW'(1)) begin
              r_state  <= c_PLAY;
              r_enable <= 1'b1;
              r_cd     <= '0;
            end else begin
              r_cd <= r_cd - 1'b1;
            end
          end
        end
        c_PLAY: begin
          if (w_exit) begin
            // Score cannot change on the exit cycle, so r_score is final here
            r_state  <= c_OVER;
            r_enable <= 1'b0;
            r_jump   <= 1'b0;
            r_cd     <= c_OVER_LD;
            if (r_score > r_high) r_high <= r_score;
          end else begin
            if (w_pass_e) begin
              r_score <= w_score_inc;
              r_fall  <= f_accel(w_score_inc[7:4]);
            end
            if (w_jump_e)    r_jump <= 1'b1;
            else if (w_tick) r_jump <= 1'b0;
          end
        end
        default: begin
          if (w_start_e && (r_cd == '0)) begin
            r_state <= c_READY;
            r_score <= 8'h00;
            r_fall  <= 2'd0;
            r_cd    <= c_READY_LD;
          end else if (w_tick && (r_cd != '0)) begin
            r_cd <= r_cd - 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.state      = r_state;
  assign bus.enable     = r_enable;
  assign bus.jump       = r_jump;
  assign bus.fall_accel = r_fall;
  assign bus.score      = r_score;
  assign bus.high_score = r_high;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// tb_game_sequencer : directed vectors and timed sequences for game_sequencer
// Rev 1.0
// ============================================================================
module tb_game_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc;
  int   n_cmp = 0;
  int   n_err = 0;

  game_sequencer_if bus_if ();

  game_sequencer #(
    .TICK_DIV    (32),
    .READY_TICKS (64),
    .OVER_TICKS  (128)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Edges since reset release; tick edges are the multiples of 32
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  typedef struct {
    int         n_pass;
    logic [7:0] exp_score;
    logic [1:0] exp_fall;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic pass_pulse();
    bus_if.pass = 1'b1;
    step(); step();
    bus_if.pass = 1'b0;
    step(); step();
  endtask

  task automatic press_start(input int n);
    to_cyc(n);
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
  endtask

  task automatic press_jump();
    bus_if.jump_btn = 1'b1;
    step(); step();
    bus_if.jump_btn = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e, f, j, t, o, m;

    tbl[0] = '{9,  8'h09, 2'd0};
    tbl[1] = '{1,  8'h10, 2'd1};
    tbl[2] = '{9,  8'h19, 2'd1};
    tbl[3] = '{1,  8'h20, 2'd2};
    tbl[4] = '{79, 8'h99, 2'd3};
    tbl[5] = '{20, 8'h99, 2'd3};

    bus_if.start    = 1'b0;
    bus_if.jump_btn = 1'b0;
    bus_if.hit      = 1'b0;
    bus_if.pass     = 1'b0;
    bus_if.y_coord  = 11'sd100;

    #12;
    chk("rst_state", bus_if.state, 2'd0);
    chk("rst_enable", bus_if.enable, 1'b0);
    chk("rst_jump", bus_if.jump, 1'b0);
    chk("rst_fall", bus_if.fall_accel, 2'd0);
    chk("rst_score", bus_if.score, 8'h00);
    chk("rst_high", bus_if.high_score, 8'h00);
    rst = 1'b1;
    step();

    // Start pulse: state moves on the third edge after the press
    bus_if.start = 1'b1;
    step(); chk("start_c2", bus_if.state, 2'd0);
    step(); chk("start_c3", bus_if.state, 2'd0);
    bus_if.start = 1'b0;
    step(); chk("start_c4", bus_if.state, 2'd1);
    chk("ready_score", bus_if.score, 8'h00);
    e = cyc;

    // Auto launch after 64 ticks
    f = (e / 32 + 64) * 32;
    to_cyc(f - 1);
    chk("ready_hold", bus_if.state, 2'd1);
    step();
    chk("launch_state", bus_if.state, 2'd2);
    chk("launch_enable", bus_if.enable, 1'b1);
    chk("launch_jump", bus_if.jump, 1'b0);

    // Jump stretch and restart at the tick edge
    while (cyc % 32 != 2) step();
    press_jump();
    j = cyc;
    t = (j / 32 + 1) * 32;
    chk("jump_set", bus_if.jump, 1'b1);
    to_cyc(t - 3);
    chk("jump_hold", bus_if.jump, 1'b1);
    bus_if.jump_btn = 1'b1;
    step();
    bus_if.jump_btn = 1'b0;
    to_cyc(t);
    chk("jump_restart", bus_if.jump, 1'b1);
    to_cyc(t + 31);
    chk("jump_hold2", bus_if.jump, 1'b1);
    step();
    chk("jump_clear", bus_if.jump, 1'b0);
    chk("jump_state", bus_if.state, 2'd2);

    // Scoring table
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < tbl[i].n_pass; k++) pass_pulse();
      step();
      chk($sformatf("score_%0d", i), bus_if.score, tbl[i].exp_score);
      chk($sformatf("fall_%0d", i), bus_if.fall_accel, tbl[i].exp_fall);
    end
    chk("play_still", bus_if.state, 2'd2);

    // Ground contact sampled on the tick
    while (cyc % 32 != 10) step();
    bus_if.y_coord = 11'sd0;
    t = (cyc / 32 + 1) * 32;
    to_cyc(t - 1);
    chk("ground_pre", bus_if.state, 2'd2);
    step();
    bus_if.y_coord = 11'sd100;
    chk("over_state", bus_if.state, 2'd3);
    chk("over_enable", bus_if.enable, 1'b0);
    chk("over_high", bus_if.high_score, 8'h99);
    chk("over_score", bus_if.score, 8'h99);
    o = cyc;

    // OVER lockout for 128 ticks
    press_start(o + 50 * 32 + 2);
    step(); step(); step();
    chk("over_ign50", bus_if.state, 2'd3);
    press_start(o + 4092);
    press_start(o + 4094);
    chk("over_ign127", bus_if.state, 2'd3);
    step();
    chk("over_wait", bus_if.state, 2'd3);
    step();
    chk("restart_state", bus_if.state, 2'd1);
    chk("restart_score", bus_if.score, 8'h00);
    chk("restart_fall", bus_if.fall_accel, 2'd0);
    chk("restart_high", bus_if.high_score, 8'h99);

    // Jump in READY launches without raising jump
    press_jump();
    chk("rdy_jump_state", bus_if.state, 2'd2);
    chk("rdy_jump_out", bus_if.jump, 1'b0);
    step();
    chk("rdy_jump_out2", bus_if.jump, 1'b0);
    press_jump();
    chk("play_jump", bus_if.jump, 1'b1);

    // Asynchronous reset mid-jump
    #3 rst = 1'b0;
    #1;
    chk("arst_state", bus_if.state, 2'd0);
    chk("arst_jump", bus_if.jump, 1'b0);
    chk("arst_enable", bus_if.enable, 1'b0);
    chk("arst_high", bus_if.high_score, 8'h00);
    #2 rst = 1'b1;
    step();

    // Simultaneous start and jump in IDLE act as start only
    bus_if.start    = 1'b1;
    bus_if.jump_btn = 1'b1;
    step(); chk("both_c2", bus_if.state, 2'd0);
    step(); chk("both_c3", bus_if.state, 2'd0);
    bus_if.start    = 1'b0;
    bus_if.jump_btn = 1'b0;
    step(); chk("both_c4", bus_if.state, 2'd1);
    step(); chk("both_c5", bus_if.state, 2'd1);

    press_jump();
    chk("p2_state", bus_if.state, 2'd2);
    pass_pulse();
    pass_pulse();
    chk("p2_score", bus_if.score, 8'h02);

    // Pass and hit together: exit wins, no increment
    m = cyc;
    bus_if.pass = 1'b1;
    bus_if.hit  = 1'b1;
    step(); step();
    bus_if.pass = 1'b0;
    bus_if.hit  = 1'b0;
    step();
    chk("ph_cyc", cyc, m + 3);
    chk("ph_state", bus_if.state, 2'd3);
    chk("ph_score", bus_if.score, 8'h02);
    chk("ph_high", bus_if.high_score, 8'h02);

    press_jump();
    step();
    chk("over_jump_out", bus_if.jump, 1'b0);
    chk("over_jump_state", bus_if.state, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
